dmem_ctrl: RTL
==============

# dmem_ctrl

Data-memory responder on the pipeline's load/store port. Accepts one load or store request at a time from the memory stage and drives a word-wide single-port synchronous RAM that has no byte enables. Performs byte/halfword lane extraction with sign/zero extension for loads, and a read-modify-write sequence for SB/SH. Returns a one-cycle response carrying load data or a store acknowledge.

## Interface
- AW, 12, RAM word-address width (RAM depth 2^AW words)
- clk  in  1  clock, all state on rising edge
- arst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept; request fires when valid & ready
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  load: LB=0 LH=1 LW=2 LBU=4 LHU=5; store: SB=0 SH=1 SW=2
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid_o  out  1  one-cycle response strobe
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  misaligned access or illegal funct3, qualified by resp_valid_o
- busy_o  out  1  FSM not in IDLE
- ram_en_o  out  1  RAM access this cycle
- ram_we_o  out  1  RAM write this cycle (only with ram_en_o)
- ram_addr_o  out  AW  word address = req_addr[AW+1:2]; upper bits ignored (wrap)
- ram_wdata_o  out  32  full-word write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after a read access

## Operation
- States: IDLE, LD_WAIT, RMW.
- req_ready_o = 1 only in IDLE and arst_n high. ram_* are combinational from state, accepted request, and latched request; all forced 0 while arst_n low.
- Error check at accept: LW/SW with addr[1:0]≠0, LH/LHU/SH with addr[0]≠0, loads with funct3 ∈ {3,6,7}, stores with funct3 ≥ 3. Error: no RAM access, stay IDLE, next cycle resp_valid=1, resp_err=1, resp_rdata=0.
- Load (legal): in accept cycle, ram_en=1, ram_we=0; latch funct3 and addr[1:0]; go LD_WAIT. In LD_WAIT: select lane from ram_rdata_i (LB/LBU byte addr[1:0], LH/LHU half addr[1]), sign-extend for LB/LH, zero-extend for LBU/LHU, whole word for LW; register into resp_rdata_o; go IDLE.
- SW (legal): in accept cycle, ram_en=1, ram_we=1, ram_wdata=req_wdata; stay IDLE; ack next cycle.
- SB/SH (legal): in accept cycle, ram read; latch addr, funct3, wdata; go RMW. In RMW: ram_en=1, ram_we=1, ram_wdata = ram_rdata_i with target lane replaced (SB: byte addr[1:0] ← wdata[7:0]; SH: half addr[1] ← wdata[15:0]); go IDLE.
- Store ack: resp_valid=1, resp_rdata=0, resp_err=0.
- No response backpressure: the pipeline must consume resp_valid_o in its cycle.
- Reset (arst_n low at an edge, any state): state←IDLE, resp_valid/resp_err/resp_rdata←0, latched request cleared. An in-flight load is dropped and an in-flight RMW write is not issued.

## Timing
- Accept at cycle T.
- Load: RAM read at T, data captured at end of T+1, resp_valid in T+2; req_ready low in T+1 only; next request can be accepted in T+2.
- SW and errors: resp_valid in T+1; next request can be accepted in T+1.
- SB/SH: read at T, write at T+1, resp_valid in T+2; req_ready low in T+1.
- RAM contract: a write at edge E is visible to a read issued in the cycle after E, so back-to-back store→load returns new data.
- Reset values: req_ready 0 while arst_n low, then 1; resp_valid 0, resp_rdata 0, resp_err 0, busy 0, all ram_* 0.

## Test plan
- Preload word 0 = 0x8040_20F1. Run LB at 0x3, LBU at 0x3, LH at 0x2, LHU at 0x2, LW at 0x0. Required rdata: 0xFFFF_FF80, 0x0000_0080, 0xFFFF_8040, 0x0000_8040, 0x8040_20F1. Each response arrives 2 cycles after accept.
- With word 1 = 0x1122_3344: SB 0xAB at 0x5 gives 0x1122_AB44; then SH 0xBEEF at 0x6 gives 0xBEEF_AB44. Check read at T and write at T+1 each time, with resp_valid at T+2.
- SW 0xDEAD_BEEF at 0x8, then LW at 0x8 accepted on the very next cycle. Required: ack at T+1, load returns 0xDEAD_BEEF.
- LW at 0x2, SH at 0x1, and load funct3=3 at 0x0. Required for each: no ram_en, resp_valid at T+1 with resp_err=1 and rdata 0.
- Assert arst_n low during RMW (cycle T+1 of an SB). Required: no RAM write, resp_valid stays 0, state IDLE, and req_ready=1 in the first cycle after arst_n goes high.
- Address 0x0000_4000 with AW=12 wraps to word 0; confirm ram_addr_o=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Load/store responder for a word-wide single-port sync RAM without byte enables.
// Sub-word loads are extracted/extended after the read; SB/SH use a read-modify-write pass.
module dmem_ctrl #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [2:0]    req_funct3_i,
  input  logic [31:0]   req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          resp_valid_o,
  output logic [31:0]   resp_rdata_o,
  output logic          resp_err_o,
  output logic          busy_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  input  logic [31:0]   ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW} state_e;

  state_e        state_q, state_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic        fire, req_err;
  logic [1:0]  req_size;
  logic [31:0] ld_shift, ld_data, lane_mask, lane_ins, rmw_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[31:AW+2];

  assign req_ready_o  = (state_q == IDLE) && arst_n;
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign fire         = req_valid_i && req_ready_o;
  assign req_size     = req_funct3_i[1:0];

  always_comb begin
    if (req_we_i) req_err = (req_funct3_i >= 3'd3);
    else          req_err = (req_funct3_i == 3'd3) || (req_funct3_i >= 3'd6);
    if (req_size == 2'd1 && req_addr_i[0])          req_err = 1'b1;
    if (req_size == 2'd2 && req_addr_i[1:0] != 2'b0) req_err = 1'b1;
  end

  // Lane select for loads: shift the addressed lane down to bit 0, then extend.
  assign ld_shift = ram_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'd4:    ld_data = {24'b0, ld_shift[7:0]};
      3'd5:    ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // RMW merge: f3_q[0] distinguishes SH from SB.
  assign lane_mask = f3_q[0] ? (32'h0000_FFFF << {off_q[1], 4'b0000})
                             : (32'h0000_00FF << {off_q, 3'b000});
  assign lane_ins  = wdata_q << {off_q, 3'b000};
  assign rmw_data  = (ram_rdata_i & ~lane_mask) | (lane_ins & lane_mask);

  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'b0;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_addr_o   = '0;
    ram_wdata_o  = 32'b0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            ram_en_o   = 1'b1;
            ram_addr_o = req_addr_i[AW+1:2];
            f3_d       = req_funct3_i;
            off_d      = req_addr_i[1:0];
            addr_d     = req_addr_i[AW+1:2];
            wdata_d    = req_wdata_i;
            if (req_we_i && req_funct3_i == 3'd2) begin
              ram_we_o     = 1'b1;
              ram_wdata_o  = req_wdata_i;
              resp_valid_d = 1'b1;
            end else if (req_we_i) begin
              state_d = RMW;
            end else begin
              state_d = LD_WAIT;
            end
          end
        end
      end
      LD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
        state_d      = IDLE;
      end
      RMW: begin
        ram_en_o     = 1'b1;
        ram_we_o     = 1'b1;
        ram_addr_o   = addr_q;
        ram_wdata_o  = rmw_data;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Suppress any RAM access (including a pending RMW write) while reset is held.
    if (!arst_n) begin
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      f3_q         <= 3'b0;
      off_q        <= 2'b0;
      addr_q       <= '0;
      wdata_q      <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule
